counter_modn_updown: RTL and testbench



---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_modn_next.sv | 36 +++
 rtl/counter_modn_updown.sv | 86 ++++++++
 tb/tb_counter_modn_updown.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
// Direction encodings and the terminal-count predicate used by the datapath and its checkers.
package counter_pkg;

   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

   // 32-bit compare so MODULUS == 2**WIDTH never overflows the count width
   function automatic logic f_is_terminal(input int unsigned count,
                                          input logic        dir,
                                          input int unsigned modulus);
      return (dir == CNT_UP) ? (count == modulus - 1) : (count == 0);
   endfunction

endpackage

// File: rtl/counter_modn_next.sv
// Next-count and wrap flag for a modulo-N up/down counter; purely combinational.
// Zero latency; no flow control.
module counter_modn_next
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic [WIDTH-1:0] count,
   input  logic             dir,
   input  logic             enable,
   output logic [WIDTH-1:0] next_count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic at_term;

   assign at_term = f_is_terminal(32'(count), dir, MODULUS);

   always_comb begin
      next_count = count;
      wrap       = 1'b0;
      if (enable) begin
         wrap = at_term;
         if (dir == CNT_UP) begin
            next_count = at_term ? '0 : count + ONE;
         end else begin
            next_count = at_term ? MAX_VAL : count - ONE;
         end
      end
   end

endmodule

// File: rtl/counter_modn_updown.sv
// Modulo-N up/down counter with clear, load, cascade terminal count and wrap/overflow status.
// Count, wrap and load-error update 1 cycle after the causing edge; tc_out is combinational.
module counter_modn_updown
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 10,
   parameter int RESET_VAL = 0
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             enable_in,
   input  logic             up_dn_in,
   input  logic             clear_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] load_val_in,
   output logic [WIDTH-1:0] count_out,
   output logic             tc_out,
   output logic             wrap_out,
   output logic             ovf_sticky_out,
   output logic             load_err_out
);

   if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_err
      $error("counter_modn_updown: MODULUS or RESET_VAL out of range");
   end

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] next_count;
   logic             wrap_nxt;
   logic             wrap_q;
   logic             ovf_q;
   logic             load_err_q;
   logic             load_ok;

   assign load_ok = (32'(load_val_in) < 32'(MODULUS));

   counter_modn_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .count      (count_q),
      .dir        (up_dn_in),
      .enable     (enable_in),
      .next_count (next_count),
      .wrap       (wrap_nxt)
   );

   // Priority: clear > load > count > hold
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         count_q    <= WIDTH'(RESET_VAL);
         wrap_q     <= 1'b0;
         ovf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
         if (clear_in) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
         end else if (load_in) begin
            if (load_ok) begin
               count_q <= load_val_in;
            end else begin
               load_err_q <= 1'b1;
            end
         end else if (enable_in) begin
            count_q <= next_count;
            if (wrap_nxt) begin
               wrap_q <= 1'b1;
               ovf_q  <= 1'b1;
            end
         end
      end
   end

   // Same-cycle carry/borrow so a chained stage sees its enable without ripple delay
   assign tc_out = enable_in & ~clear_in & ~load_in & f_is_terminal(32'(count_q), up_dn_in, MODULUS);

   assign count_out      = count_q;
   assign wrap_out       = wrap_q;
   assign ovf_sticky_out = ovf_q;
   assign load_err_out   = load_err_q;

endmodule

// File: tb/tb_counter_modn_updown.sv
// Directed bench: vector table for the mod-10 instance, plus cascade and mod-16 sequences.
module tb_counter_modn_updown;

   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- main instance: WIDTH=4, MODULUS=10 ----------------
   logic       rst_n, en, up, clr, ld;
   logic [3:0] ldv, cnt;
   logic       tc, wr, ov, er;

   counter_modn_updown #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
      .clk_in(clk), .reset_in(rst_n), .enable_in(en), .up_dn_in(up),
      .clear_in(clr), .load_in(ld), .load_val_in(ldv),
      .count_out(cnt), .tc_out(tc), .wrap_out(wr),
      .ovf_sticky_out(ov), .load_err_out(er)
   );

   // ---------------- cascade: two mod-10 digits ----------------
   logic       rstc, en_lo;
   logic [3:0] cnt_lo, cnt_hi;
   logic       tc_lo, tc_hi, wr_lo, wr_hi, ov_lo, ov_hi, er_lo, er_hi;

   counter_modn_updown #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_lo (
      .clk_in(clk), .reset_in(rstc), .enable_in(en_lo), .up_dn_in(1'b1),
      .clear_in(1'b0), .load_in(1'b0), .load_val_in(4'd0),
      .count_out(cnt_lo), .tc_out(tc_lo), .wrap_out(wr_lo),
      .ovf_sticky_out(ov_lo), .load_err_out(er_lo)
   );

   counter_modn_updown #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_hi (
      .clk_in(clk), .reset_in(rstc), .enable_in(tc_lo), .up_dn_in(1'b1),
      .clear_in(1'b0), .load_in(1'b0), .load_val_in(4'd0),
      .count_out(cnt_hi), .tc_out(tc_hi), .wrap_out(wr_hi),
      .ovf_sticky_out(ov_hi), .load_err_out(er_hi)
   );

   // ---------------- full-range instance: MODULUS=16, RESET_VAL=5 ----------------
   logic       rst16, en16, up16;
   logic [3:0] cnt16;
   logic       tc16, wr16, ov16, er16;

   counter_modn_updown #(.WIDTH(4), .MODULUS(16), .RESET_VAL(5)) dut16 (
      .clk_in(clk), .reset_in(rst16), .enable_in(en16), .up_dn_in(up16),
      .clear_in(1'b0), .load_in(1'b0), .load_val_in(4'd0),
      .count_out(cnt16), .tc_out(tc16), .wrap_out(wr16),
      .ovf_sticky_out(ov16), .load_err_out(er16)
   );

   typedef struct {
      logic       clr;
      logic       ld;
      logic [3:0] val;
      logic       en;
      logic       up;
      logic       tc;   // expected before the edge
      logic [3:0] cnt;  // expected after the edge
      logic       wr;
      logic       ov;
      logic       er;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic c, input logic l, input logic [3:0] v, input logic e,
                      input logic u, input logic t, input logic [3:0] n,
                      input logic w, input logic o, input logic r);
      vec_t x;
      x.clr = c; x.ld = l; x.val = v; x.en = e; x.up = u;
      x.tc = t; x.cnt = n; x.wr = w; x.ov = o; x.er = r;
      vt.push_back(x);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; ld = 1'b0; ldv = 4'd0;
      rstc = 1'b0; en_lo = 1'b0;
      rst16 = 1'b0; en16 = 1'b0; up16 = 1'b1;

      //   clr ld val en up | tc cnt wr ov er
      // count up 0..9,0,1
      add(0, 0, 0, 1, 1,  0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 1,  0, 2, 0, 0, 0);
      add(0, 0, 0, 1, 1,  0, 3, 0, 0, 0);
      add(0, 0, 0, 1, 1,  0, 4, 0, 0, 0);
      add(0, 0, 0, 1, 1,  0, 5, 0, 0, 0);
      add(0, 0, 0, 1, 1,  0, 6, 0, 0, 0);
      add(0, 0, 0, 1, 1,  0, 7, 0, 0, 0);
      add(0, 0, 0, 1, 1,  0, 8, 0, 0, 0);
      add(0, 0, 0, 1, 1,  0, 9, 0, 0, 0);
      add(0, 0, 0, 1, 1,  1, 0, 1, 1, 0);
      add(0, 0, 0, 1, 1,  0, 1, 0, 1, 0);
      // load 3 then count down 3,2,1,0,9,8
      add(0, 1, 3, 1, 1,  0, 3, 0, 1, 0);
      add(0, 0, 0, 1, 0,  0, 2, 0, 1, 0);
      add(0, 0, 0, 1, 0,  0, 1, 0, 1, 0);
      add(0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0,  1, 9, 1, 1, 0);
      add(0, 0, 0, 1, 0,  0, 8, 0, 1, 0);
      // illegal loads are rejected, legal load of MODULUS-1 accepted
      add(0, 1, 12, 1, 0, 0, 8, 0, 1, 1);
      add(0, 0, 0, 0, 0,  0, 8, 0, 1, 0);
      add(0, 1, 9, 0, 0,  0, 9, 0, 1, 0);
      add(0, 1, 10, 0, 0, 0, 9, 0, 1, 1);
      // clear on the same edge as an up-wrap
      add(1, 0, 0, 1, 1,  0, 0, 0, 0, 0);
      // count at 0 but disabled: no terminal count
      add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      // direction change on consecutive edges, then borrow wrap
      add(0, 0, 0, 1, 1,  0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0,  1, 9, 1, 1, 0);
      // clear beats load; load masks terminal count
      add(1, 1, 5, 1, 1,  0, 0, 0, 0, 0);
      add(0, 1, 15, 0, 1, 0, 0, 0, 0, 1);
      add(0, 1, 9, 0, 1,  0, 9, 0, 0, 0);
      add(0, 1, 2, 1, 1,  0, 2, 0, 0, 0);

      // Test 1 reset state
      #20;
      chk("rst_count", cnt, 0);
      chk("rst_wrap", wr, 0);
      chk("rst_ovf", ov, 0);
      chk("rst_lderr", er, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         clr = vt[i].clr; ld = vt[i].ld; ldv = vt[i].val; en = vt[i].en; up = vt[i].up;
         #1;
         chk($sformatf("v%0d_tc", i), tc, vt[i].tc);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_count", i), cnt, vt[i].cnt);
         chk($sformatf("v%0d_wrap", i), wr, vt[i].wr);
         chk($sformatf("v%0d_ovf", i), ov, vt[i].ov);
         chk($sformatf("v%0d_lderr", i), er, vt[i].er);
      end
      @(negedge clk);
      en = 1'b0; ld = 1'b0; clr = 1'b0;

      // Test 5: cascade walks 00..99 then 00
      @(negedge clk);
      rstc = 1'b1;
      en_lo = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("casc_%0d", k), cnt_hi * 10 + cnt_lo, k % 100);
      end
      chk("casc_hi_wrap", wr_hi, 1);
      @(negedge clk);
      en_lo = 1'b0;

      // Test 6: full-range modulus, non-zero reset value
      chk("m16_rst_count", cnt16, 5);
      @(negedge clk);
      rst16 = 1'b1;
      en16 = 1'b1;
      up16 = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) chk("m16_tc_at15", tc16, 1);
         @(posedge clk);
         #1;
         chk($sformatf("m16_up_%0d", k), cnt16, (5 + k) % 16);
      end
      chk("m16_wrap_up", wr16, 1);
      @(negedge clk);
      up16 = 1'b0;
      #1;
      chk("m16_tc_at0", tc16, 1);
      @(posedge clk);
      #1;
      chk("m16_down_wrap_count", cnt16, 15);
      chk("m16_down_wrap_pulse", wr16, 1);
      @(posedge clk);
      #1;
      chk("m16_down_14", cnt16, 14);
      chk("m16_ovf_held", ov16, 1);
      // asynchronous reset pulse between edges
      #1;
      rst16 = 1'b0;
      #1;
      chk("m16_async_count", cnt16, 5);
      chk("m16_async_ovf", ov16, 0);
      #1;
      rst16 = 1'b1;
      @(posedge clk);
      #1;
      chk("m16_after_rst", cnt16, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
